// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take priority; loads are sign/zero-extended on accept and queued in a 2-entry FIFO.
// Optional `WB_HAZARD_EN adds rs1_addr/rs2_addr inputs and a ld_hazard output for pending-load dependency detection.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_rdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
`ifdef WB_HAZARD_EN
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        ld_hazard,
`endif
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] write_data,
  output logic [1:0]  pend_cnt
);

  // Each FIFO entry is {rd[4:0], data[31:0]}; slot 0 is always the head.
  logic [1:0][36:0] fifo_q, fifo_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_addr_q, wb_addr_d;
  logic [31:0]      write_data_q, write_data_d;

  logic        accept, bypass, pop, push, push_slot;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  always_comb begin
    case (ld_offset)
      2'd0:    byte_sel = ld_rdata[7:0];
      2'd1:    byte_sel = ld_rdata[15:8];
      2'd2:    byte_sel = ld_rdata[23:16];
      default: byte_sel = ld_rdata[31:24];
    endcase
    half_sel = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_data = {24'd0, byte_sel};
      3'b101:  ext_data = {16'd0, half_sel};
      default: ext_data = ld_rdata;
    endcase
  end

  always_comb begin
    ld_ready  = (cnt_q != 2'd2);
    accept    = ld_valid && ld_ready;
    pop       = !alu_valid && (cnt_q != 2'd0);
    bypass    = accept && !alu_valid && (cnt_q == 2'd0);
    push      = accept && !bypass;
    // A push never happens at occupancy 2, so the free slot is 1 only when one entry stays put.
    push_slot = (cnt_q == 2'd1) && !pop;

    fifo_d = fifo_q;
    if (pop)
      fifo_d[0] = fifo_q[1];
    if (push)
      fifo_d[push_slot] = {ld_rd, ext_data};

    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + 2'd1;
    else if (pop && !push)
      cnt_d = cnt_q - 2'd1;

    wb_en_d      = 1'b0;
    wb_addr_d    = wb_addr_q;
    write_data_d = write_data_q;
    if (alu_valid) begin
      wb_en_d      = (alu_rd != 5'd0);
      wb_addr_d    = alu_rd;
      write_data_d = alu_data;
    end else if (pop) begin
      wb_en_d      = (fifo_q[0][36:32] != 5'd0);
      wb_addr_d    = fifo_q[0][36:32];
      write_data_d = fifo_q[0][31:0];
    end else if (bypass) begin
      wb_en_d      = (ld_rd != 5'd0);
      wb_addr_d    = ld_rd;
      write_data_d = ext_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q       <= '0;
      cnt_q        <= 2'd0;
      wb_en_q      <= 1'b0;
      wb_addr_q    <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      fifo_q       <= fifo_d;
      cnt_q        <= cnt_d;
      wb_en_q      <= wb_en_d;
      wb_addr_q    <= wb_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign wb_en      = wb_en_q;
  assign wb_addr    = wb_addr_q;
  assign write_data = write_data_q;
  assign pend_cnt   = cnt_q;

`ifdef WB_HAZARD_EN
  function automatic logic src_match(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return (rd != 5'd0) && ((rd == a) || (rd == b));
  endfunction

  always_comb begin
    ld_hazard = ((cnt_q != 2'd0) && src_match(fifo_q[0][36:32], rs1_addr, rs2_addr)) ||
                ((cnt_q == 2'd2) && src_match(fifo_q[1][36:32], rs1_addr, rs2_addr)) ||
                (accept && src_match(ld_rd, rs1_addr, rs2_addr));
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized + directed bench for wb_arbiter against a queue-based writeback model.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_rdata;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] write_data;
  logic [1:0]  pend_cnt;
`ifdef WB_HAZARD_EN
  logic [4:0]  rs1_addr = 5'd0;
  logic [4:0]  rs2_addr = 5'd0;
  logic        ld_hazard;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: pending loads as {rd, data}, and the expected registered outputs.
  logic [36:0] model_q[$];
  logic        exp_en;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
    .ld_rdata(ld_rdata), .ld_funct3(ld_funct3), .ld_offset(ld_offset),
`ifdef WB_HAZARD_EN
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .ld_hazard(ld_hazard),
`endif
    .wb_en(wb_en), .wb_addr(wb_addr), .write_data(write_data), .pend_cnt(pend_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic compare_outputs();
    check("wb_en", {31'd0, wb_en}, {31'd0, exp_en});
    check("wb_addr", {27'd0, wb_addr}, {27'd0, exp_addr});
    check("write_data", write_data, exp_data);
    check("pend_cnt", {30'd0, pend_cnt}, model_q.size());
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] lw,
                      input logic [2:0] f3, input logic [1:0] off);
    logic        acc;
    logic [31:0] ext;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_rdata = lw; ld_funct3 = f3; ld_offset = off;
    #1;
    check("ld_ready", {31'd0, ld_ready}, {31'd0, model_q.size() < 2});
    acc = lv && (model_q.size() < 2);
    ext = extract(lw, f3, off);
`ifdef WB_HAZARD_EN
    begin
      logic hz = 1'b0;
      foreach (model_q[i])
        if (model_q[i][36:32] != 0 && (model_q[i][36:32] == rs1_addr || model_q[i][36:32] == rs2_addr)) hz = 1'b1;
      if (acc && lrd != 0 && (lrd == rs1_addr || lrd == rs2_addr)) hz = 1'b1;
      check("ld_hazard", {31'd0, ld_hazard}, {31'd0, hz});
    end
`endif
    if (av) begin
      exp_en = (ard != 0); exp_addr = ard; exp_data = ad;
      if (acc) model_q.push_back({lrd, ext});
    end else if (model_q.size() > 0) begin
      logic [36:0] head = model_q.pop_front();
      exp_en = (head[36:32] != 0); exp_addr = head[36:32]; exp_data = head[31:0];
      if (acc) model_q.push_back({lrd, ext});
    end else if (acc) begin
      exp_en = (lrd != 0); exp_addr = lrd; exp_data = ext;
    end else begin
      exp_en = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_en = 1'b0; exp_addr = 5'd0; exp_data = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_rdata = 0; ld_funct3 = 0; ld_offset = 0;
    model_reset();
    @(negedge clk);
    compare_outputs();
    check("ld_ready_reset", {31'd0, ld_ready}, 32'd1);
    rst = 1'b0;

    // LB sign-extension through the bypass path
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345680, 3'b000, 2'd0);
    check("lb_en", {31'd0, wb_en}, 32'd1);
    check("lb_addr", {27'd0, wb_addr}, 32'd5);
    check("lb_data", write_data, 32'hFFFFFF80);

    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h80010000, 3'b101, 2'd2);
    check("lhu_data", write_data, 32'h00008001);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h80010000, 3'b001, 2'd2);
    check("lh_data", write_data, 32'hFFFF8001);
    idle();
    check("idle_en", {31'd0, wb_en}, 32'd0);
    check("idle_hold", write_data, 32'hFFFF8001);

    // ALU priority while three loads are offered
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        alu_valid = 1'b1; ld_valid = 1'b1;
        #1 check("ready_full", {31'd0, ld_ready}, 32'd0);
      end
      step(1'b1, 5'(20 + i), 32'hA0 + i, 1'b1, 5'(10 + i), 32'h100 + i, 3'b010, 2'd0);
      check("alu_addr", {27'd0, wb_addr}, 20 + i);
    end
    check("pend_two", {30'd0, pend_cnt}, 32'd2);
    idle();
    check("drain1_addr", {27'd0, wb_addr}, 32'd10);
    check("pend_one", {30'd0, pend_cnt}, 32'd1);
    idle();
    check("drain2_addr", {27'd0, wb_addr}, 32'd11);
    check("pend_zero", {30'd0, pend_cnt}, 32'd0);

    // rd=0 writebacks are consumed silently
    step(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'h55, 3'b010, 2'd0);
    check("alu_rd0_en", {31'd0, wb_en}, 32'd0);
    check("ld_rd0_pend", {30'd0, pend_cnt}, 32'd1);
    idle();
    check("ld_rd0_en", {31'd0, wb_en}, 32'd0);
    check("ld_rd0_drained", {30'd0, pend_cnt}, 32'd0);

`ifdef WB_HAZARD_EN
    rs2_addr = 5'd7;
    step(1'b1, 5'd1, 32'd1, 1'b1, 5'd7, 32'h77, 3'b010, 2'd0);
    #1 check("hazard_set", {31'd0, ld_hazard}, 32'd1);
    idle();
    #1 check("hazard_clear", {31'd0, ld_hazard}, 32'd0);
    rs2_addr = 5'd0;
    @(negedge clk);
    idle();
`endif

    // Reset in the middle of a cycle with a full FIFO
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88, 3'b010, 2'd0);
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99, 3'b010, 2'd0);
    check("pre_rst_pend", {30'd0, pend_cnt}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("rst_en", {31'd0, wb_en}, 32'd0);
    check("rst_addr", {27'd0, wb_addr}, 32'd0);
    check("rst_data", write_data, 32'd0);
    check("rst_pend", {30'd0, pend_cnt}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle();
    check("post_rst_en", {31'd0, wb_en}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd_a, rd_l;
      rd_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rd_l = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
`ifdef WB_HAZARD_EN
      rs1_addr = 5'($urandom); rs2_addr = 5'($urandom);
`endif
      step($urandom_range(0, 9) < 4, rd_a, $urandom,
           $urandom_range(0, 9) < 6, rd_l, $urandom, 3'($urandom), 2'($urandom));
    end
    for (int i = 0; i < 4; i++) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
